aes_stream_ctrl: RTL and testbench

Upstream sequencing stage for the 128-bit AES encryption core. It accepts plaintext/key blocks over a valid/ready stream, holds them stable at the core inputs, and restarts the core's iterative round logic through a generated core reset. It counts the fixed core latency, captures the ciphertext and presents it on a valid/ready output stream, so the free-running core becomes a flow-controlled block engine.

---
 rtl/aes_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_aes_stream_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: valid/ready block sequencer around an iterative AES-128 core.
// Define AES_STREAM_CTRL_PREFETCH_EN for a one-entry input prefetch register.
module aes_stream_ctrl #(
  parameter int N        = 128,
  parameter int R        = 10,
  parameter int CORE_LAT = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_pt,
  input  logic [N-1:0] in_key,
  output logic [N-1:0] core_pt,
  output logic [N-1:0] core_key,
  output logic         core_rst_n,
  input  logic [N-1:0] core_ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_ct,
  output logic         busy,
  output logic [15:0]  blk_cnt
);

  localparam int CW = $clog2(CORE_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CORE_LAT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CORE_LAT);

  if (CORE_LAT < 1 || R < 1) begin : g_param_check
    $error("aes_stream_ctrl: CORE_LAT and R must both be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          in_hs, out_hs, run_last, load_core;
  logic [N-1:0]  load_pt, load_key;

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign run_last = (state == RUN) && (cnt == CNT_LAST);

`ifdef AES_STREAM_CTRL_PREFETCH_EN
  logic         pend_full, promote, direct, fill;
  logic [N-1:0] pend_pt, pend_key;

  assign in_ready = !rst && ((state == IDLE) || !pend_full);
  assign promote  = (state == DONE) && out_hs && pend_full;
  // A block goes straight to the core when the core is free at that edge.
  assign direct   = in_hs && ((state == IDLE) || ((state == DONE) && out_hs && !pend_full));
  assign fill     = in_hs && !direct;

  assign load_core = direct || promote;
  assign load_pt   = promote ? pend_pt  : in_pt;
  assign load_key  = promote ? pend_key : in_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
    end else if (fill) begin
      pend_full <= 1'b1;
    end else if (promote) begin
      pend_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      pend_pt  <= in_pt;
      pend_key <= in_key;
    end
  end
`else
  assign in_ready  = !rst && (state == IDLE);
  assign load_core = in_hs;
  assign load_pt   = in_pt;
  assign load_key  = in_key;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_hs) state_nxt = load_core ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy and core_rst_n are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      core_pt    <= '0;
      core_key   <= '0;
      core_rst_n <= 1'b0;
      out_ct     <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      core_rst_n <= (state_nxt != LOAD);
      if (state == LOAD) begin
        cnt <= '0;
      end else if (state == RUN && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (load_core) begin
        core_pt  <= load_pt;
        core_key <= load_key;
      end
      if (run_last) begin
        out_ct    <= core_ct;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (out_hs) begin
        blk_cnt <= blk_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: stand-in AES core, output scoreboard, scenario tasks.
// Prefetch scenarios run when AES_STREAM_CTRL_PREFETCH_EN is defined.
`timescale 1ns/1ps
module tb_aes_stream_ctrl;
  localparam int N  = 128;
  localparam int CL = 11;
`ifdef AES_STREAM_CTRL_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam logic [N-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [N-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [N-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [N-1:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, core_rst_n, out_valid, busy;
  logic [N-1:0] in_pt = '0, in_key = '0;
  logic [N-1:0] core_pt, core_key, core_ct, out_ct;
  logic [15:0]  blk_cnt;

  int checks = 0, errors = 0, cycle = 0, core_age = 0;
  int acc_cycle = 0, ov_cycle = 0;
  logic [N-1:0] sb[$];
  logic [N-1:0] sb_exp;

  aes_stream_ctrl #(.N(N), .R(10), .CORE_LAT(CL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pt(in_pt), .in_key(in_key), .core_pt(core_pt), .core_key(core_key),
    .core_rst_n(core_rst_n), .core_ct(core_ct), .out_valid(out_valid),
    .out_ready(out_ready), .out_ct(out_ct), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Stand-in core: known vectors answer with real AES results, others with a cheap mix.
  function automatic logic [N-1:0] cipher(input logic [N-1:0] k, input logic [N-1:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    if (k == '0 && p == '0) return ZERO_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Ciphertext is garbage (inverted) until CL-1 cycles after the restart is released.
  always @(posedge clk) begin
    if (!core_rst_n) core_age <= 0;
    else if (core_age < 1000) core_age <= core_age + 1;
  end
  always_comb core_ct = (core_age >= CL - 1) ? cipher(core_key, core_pt) : ~cipher(core_key, core_pt);

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_valid && in_ready) sb.push_back(cipher(in_key, in_pt));
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got out_ct %h, expected no output", out_ct);
          end else begin
            sb_exp = sb.pop_front();
            if (out_ct !== sb_exp) begin
              errors++;
              $display("FAIL sb_ct: got %h, expected %h", out_ct, sb_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [N-1:0] k, input logic [N-1:0] p);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_key = k; in_pt = p;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cycle = cycle;
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          checks++; errors++;
          $display("FAIL send_timeout: in_ready low for %0d cycles, expected high", n);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input logic lvl);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (out_valid === lvl) begin
        ov_cycle = cycle;
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          checks++; errors++;
          $display("FAIL wait_out_valid: out_valid stuck at %b, expected %b", out_valid, lvl);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
    checks++;
    if ({out_valid, busy, core_rst_n} !== 3'b000) begin
      errors++; $display("FAIL rst_ctrl: got out_valid/busy/core_rst_n %b, expected 000", {out_valid, busy, core_rst_n});
    end
    checks++;
    if (blk_cnt !== 16'h0) begin errors++; $display("FAIL rst_blk_cnt: got %h, expected 0000", blk_cnt); end
    checks++;
    if ({core_pt, core_key, out_ct} !== '0) begin
      errors++; $display("FAIL rst_data: got pt %h key %h ct %h, expected all zero", core_pt, core_key, out_ct);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, core_rst_n, busy, out_valid} !== 4'b1100) begin
      errors++; $display("FAIL idle_ctrl: got in_ready/core_rst_n/busy/out_valid %b, expected 1100", {in_ready, core_rst_n, busy, out_valid});
    end
  endtask

  task automatic test_fips();
    int acc, lat;
    out_ready = 1'b1;
    send(FIPS_KEY, FIPS_PT);
    acc = acc_cycle;
    wait_ov(1'b1);
    lat = ov_cycle - acc;
    checks++;
    if (lat != CL + 2) begin errors++; $display("FAIL fips_latency: got %0d cycles, expected %0d", lat, CL + 2); end
    checks++;
    if (out_ct !== FIPS_CT) begin errors++; $display("FAIL fips_ct: got %h, expected %h", out_ct, FIPS_CT); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (blk_cnt !== 16'd1) begin errors++; $display("FAIL fips_blk_cnt: got %0d, expected 1", blk_cnt); end
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL fips_idle: got out_valid/busy %b, expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] k, p;
    int bad;
    k = 128'hfedcba98765432100123456789abcdef;
    p = 128'h0badc0de00000001deadbeefcafef00d;
    out_ready = 1'b0;
    send(k, p);
    wait_ov(1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({out_valid, in_ready, out_ct, core_pt, core_key} !== {1'b1, PF, cipher(k, p), p, k}) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d deviating cycles of 20, expected 0", bad); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL bp_release: got out_valid/busy %b, expected 00", {out_valid, busy});
    end
    checks++;
    if (blk_cnt !== 16'd2) begin errors++; $display("FAIL bp_blk_cnt: got %0d, expected 2", blk_cnt); end
  endtask

  task automatic test_reset_run();
    int seen;
    out_ready = 1'b1;
    send(128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888);
    // LOAD after the accepting edge, counter 0 one edge later: five more edges reach 5.
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, core_rst_n} !== 4'b0000) begin
      errors++; $display("FAIL rstrun_ctrl: got in_ready/out_valid/busy/core_rst_n %b, expected 0000", {in_ready, out_valid, busy, core_rst_n});
    end
    checks++;
    if ({core_pt, core_key, out_ct, blk_cnt} !== '0) begin
      errors++; $display("FAIL rstrun_data: got pt %h key %h ct %h cnt %h, expected all zero", core_pt, core_key, out_ct, blk_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    seen = 0;
    repeat (2 * CL + 4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstrun_no_output: got out_valid in %0d cycles, expected 0", seen); end
    checks++;
    if ({blk_cnt, busy} !== 17'h0) begin
      errors++; $display("FAIL rstrun_idle: got blk_cnt %h busy %b, expected 0000 0", blk_cnt, busy);
    end
  endtask

  task automatic test_wrap();
    force dut.blk_cnt = 16'hFFFF;
    #1;
    release dut.blk_cnt;
    @(negedge clk);
    checks++;
    if (blk_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h, expected ffff", blk_cnt); end
    out_ready = 1'b1;
    send(128'h0123456789abcdef0123456789abcdef, 128'h13579bdf2468ace013579bdf2468ace0);
    wait_ov(1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (blk_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_blk_cnt: got %h, expected 0000", blk_cnt); end
  endtask

`ifdef AES_STREAM_CTRL_PREFETCH_EN
  task automatic test_back_to_back();
    int acc1, acc2, r1, gap;
    out_ready = 1'b1;
    send(FIPS_KEY, FIPS_PT);
    acc1 = acc_cycle;
    send('0, '0);
    acc2 = acc_cycle;
    // Cycle after acceptance is LOAD, the one after that is the first RUN cycle.
    checks++;
    if (acc2 - acc1 != 2) begin errors++; $display("FAIL b2b_accept_run: got accept offset %0d, expected 2", acc2 - acc1); end
    @(negedge clk);
    checks++;
    if ({in_ready, core_pt, core_key} !== {1'b0, FIPS_PT, FIPS_KEY}) begin
      errors++; $display("FAIL b2b_pending: got in_ready %b pt %h, expected 0 pt %h", in_ready, core_pt, FIPS_PT);
    end
    wait_ov(1'b1);
    r1 = ov_cycle;
    checks++;
    if (out_ct !== FIPS_CT) begin errors++; $display("FAIL b2b_ct1: got %h, expected %h", out_ct, FIPS_CT); end
    wait_ov(1'b0);
    wait_ov(1'b1);
    gap = ov_cycle - r1;
    checks++;
    if (gap != CL + 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles, expected %0d", gap, CL + 2); end
    checks++;
    if (out_ct !== ZERO_CT) begin errors++; $display("FAIL b2b_ct2: got %h, expected %h", out_ct, ZERO_CT); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b, expected 0", busy); end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] ka, pa, kb, pb;
    int low;
    ka = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5; pa = 128'h00000000000000000000000000000001;
    kb = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a; pb = 128'h80000000000000000000000000000000;
    out_ready = 1'b0;
    send(ka, pa);
    wait_ov(1'b1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_key = kb; in_pt = pb; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b11) begin
      errors++; $display("FAIL sim_both_hs: got in_ready/out_valid %b, expected 11", {in_ready, out_valid});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_pt, core_key} !== {pb, kb}) begin
      errors++; $display("FAIL sim_core_in: got pt %h key %h, expected pt %h key %h", core_pt, core_key, pb, kb);
    end
    checks++;
    if ({core_rst_n, busy, out_valid} !== 3'b010) begin
      errors++; $display("FAIL sim_load: got core_rst_n/busy/out_valid %b, expected 010", {core_rst_n, busy, out_valid});
    end
    low = 1;
    repeat (CL + 4) begin
      @(negedge clk);
      if (!core_rst_n) low++;
    end
    checks++;
    if (low != 1) begin errors++; $display("FAIL sim_rst_pulse: got core_rst_n low %0d cycles, expected 1", low); end
  endtask
`endif

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_reset_run();
    test_wrap();
`ifdef AES_STREAM_CTRL_PREFETCH_EN
    test_back_to_back();
    test_simultaneous();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d outstanding blocks, expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
